// File: rtl/tlb.sv
// Fully associative Sv39 TLB (4 KiB pages only) sitting between a core memory
// stage and the page table walker. It translates virtual addresses, checks
// PTE permissions against the current privilege, requests a walk on a miss
// and installs the leaf PTE that the walker returns.
module tlb #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   mpp,
    input  logic [63:0]  satp,
    input  logic         flush,
    input  logic         lookup_valid,
    output logic         lookup_ready,
    input  logic [63:0]  lookup_vaddr,
    input  logic         lookup_is_store,
    input  logic         lookup_is_execute,
    output logic         resp_valid,
    output logic [63:0]  resp_paddr,
    output logic         resp_fault,
    output logic         ptw_req_valid,
    output logic [63:0]  ptw_req_addr,
    output logic         ptw_req_is_store,
    output logic         ptw_req_is_execute,
    input  logic         ptw_fill,
    input  logic [26:0]  ptw_fill_tag,
    input  logic [63:0]  ptw_fill_pte
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_WALK   = 1'b1;
    localparam logic [3:0] MODE_SV39 = 4'd8;

    // Flags are kept compacted as {D, A, U, X, W, R, V}; G is not needed here.
    // Result bit 0: access allowed. Result bit 1: everything passes except D=0 on a store.
    function automatic logic [1:0] pte_check(input logic [6:0] fl, input logic [1:0] priv,
                                             input logic is_store, input logic is_exec);
        logic perm;
        logic u_ok;
        logic base;
        perm = is_store ? fl[2] : (is_exec ? fl[3] : fl[1]);
        u_ok = (priv == 2'd0) ? fl[4] : ~fl[4];
        base = fl[0] & fl[5] & perm & u_ok;
        return {base & is_store & ~fl[6], base & (~is_store | fl[6])};
    endfunction

    logic [0:0]       state;
    logic             flush_seen;
    logic [ENTRIES-1:0] valid_q;
    logic [26:0]      tag_q   [ENTRIES];
    logic [43:0]      ppn_q   [ENTRIES];
    logic [6:0]       flags_q [ENTRIES];
    logic [IDX_W-1:0] rr_ptr;

    logic             hit_any;
    logic [IDX_W-1:0] hit_idx;
    logic [43:0]      hit_ppn;
    logic [6:0]       hit_flags;
    logic [IDX_W-1:0] victim;
    logic [1:0]       hit_chk;
    logic [1:0]       fill_chk;
    logic [6:0]       fill_flags;
    logic             accept;
    logic             bypass;
    logic             dirty_inval;
    logic             install;
    logic             unused_bits;

    assign lookup_ready = (state == ST_IDLE) & ~flush;
    assign accept       = lookup_valid & lookup_ready;
    assign bypass       = (satp[63:60] != MODE_SV39) | (mpp == 2'd3);
    assign hit_chk      = pte_check(hit_flags, mpp, lookup_is_store, lookup_is_execute);
    assign fill_flags   = {ptw_fill_pte[7:6], ptw_fill_pte[4:0]};
    assign fill_chk     = pte_check(fill_flags, mpp, ptw_req_is_store, ptw_req_is_execute);
    assign dirty_inval  = accept & ~bypass & hit_any & hit_chk[1];
    assign install      = (state == ST_WALK) & ptw_fill & fill_chk[0] & ~flush & ~flush_seen;
    assign unused_bits  = ^{satp[59:0], lookup_vaddr[63:39], ptw_fill_pte[63:54],
                            ptw_fill_pte[9:8], ptw_fill_pte[5]};

    // Associative match of the request page against every valid entry.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        hit_any   = 1'b0;
        hit_idx   = '0;
        hit_ppn   = '0;
        hit_flags = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == lookup_vaddr[38:12]) begin
                hit_any   = 1'b1;
                hit_idx   = IDX_W'(i);
                hit_ppn   = ppn_q[i];
                hit_flags = flags_q[i];
            end
        end
    end

    // Victim choice: lowest-index invalid entry, else the round-robin pointer.
    always_comb begin
        victim = rr_ptr;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) victim = IDX_W'(i);
        end
    end

    // Request/walk control and the registered response and walk-request outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state              <= ST_IDLE;
            flush_seen         <= 1'b0;
            resp_valid         <= 1'b0;
            resp_paddr         <= '0;
            resp_fault         <= 1'b0;
            ptw_req_valid      <= 1'b0;
            ptw_req_addr       <= '0;
            ptw_req_is_store   <= 1'b0;
            ptw_req_is_execute <= 1'b0;
        end else begin
            resp_valid    <= 1'b0;
            ptw_req_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (bypass) begin
                            resp_valid <= 1'b1;
                            resp_paddr <= lookup_vaddr;
                            resp_fault <= 1'b0;
                        end else if (hit_any && hit_chk[0]) begin
                            resp_valid <= 1'b1;
                            resp_paddr <= {8'b0, hit_ppn, lookup_vaddr[11:0]};
                            resp_fault <= 1'b0;
                        end else if (hit_any && !hit_chk[1]) begin
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                        end else begin
                            // True miss, or a store hit that only lacks D: walk the page.
                            ptw_req_valid      <= 1'b1;
                            ptw_req_addr       <= lookup_vaddr;
                            ptw_req_is_store   <= lookup_is_store;
                            ptw_req_is_execute <= lookup_is_execute;
                            flush_seen         <= 1'b0;
                            state              <= ST_WALK;
                        end
                    end
                end
                ST_WALK: begin
                    if (flush) flush_seen <= 1'b1;
                    if (ptw_fill) begin
                        resp_valid <= 1'b1;
                        if (fill_chk[0]) begin
                            resp_paddr <= {8'b0, ptw_fill_pte[53:10], ptw_req_addr[11:0]};
                            resp_fault <= 1'b0;
                        end else begin
                            resp_fault <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Valid bits and replacement pointer: flush wins over invalidation and install.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            rr_ptr  <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            if (dirty_inval) valid_q[hit_idx] <= 1'b0;
            if (install) begin
                valid_q[victim] <= 1'b1;
                if (victim == rr_ptr) rr_ptr <= rr_ptr + 1'b1;
            end
        end
    end

    // Entry payload written on install.
    always_ff @(posedge clk) begin
        // NOTE: payload arrays are not reset; valid_q alone qualifies their contents.
        if (install) begin
            tag_q[victim]   <= ptw_fill_tag;
            ppn_q[victim]   <= ptw_fill_pte[53:10];
            flags_q[victim] <= fill_flags;
        end
    end

endmodule
